// File: rtl/multicycle_control.sv
// Moore sequencer for a multicycle MIPS datapath (fetch/decode/exec/mem/wb).
// In: clk, rst_n, opcode, funct, zero. Out: ALU/mux selects, strobes, state.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] ALUcontrol,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCEn,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] state_q, state_d;
  logic       rtype_ok;
  logic       pcwrite, branch;
  logic       irwrite, memwrite, regwrite;

  always_comb begin
    rtype_ok = funct inside {6'b100000, 6'b100010,
                             6'b100100, 6'b100101,
                             6'b101010};
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          opcode == OP_R:
            state_d = rtype_ok ? S_EXECUTE : S_FETCH;
          opcode == OP_LW,
          opcode == OP_SW:   state_d = S_MEMADR;
          opcode == OP_BEQ:  state_d = S_BRANCH;
          opcode == OP_ADDI: state_d = S_ADDIEX;
          opcode == OP_J:    state_d = S_JUMP;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    ALUcontrol = 3'b010;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        case (funct)
          6'b100010: ALUcontrol = 3'b110;
          6'b100100: ALUcontrol = 3'b001;
          6'b100101: ALUcontrol = 3'b000;
          6'b101010: ALUcontrol = 3'b111;
          default:   ALUcontrol = 3'b010;
        endcase
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUcontrol = 3'b110;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        PCSrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are forced low while reset is held, independent of state.
  assign IRWrite  = irwrite  & rst_n;
  assign MemWrite = memwrite & rst_n;
  assign RegWrite = regwrite & rst_n;
  assign PCEn     = (pcwrite | (branch & zero)) & rst_n;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction stream checked
// against a per-instruction step model of expected control outputs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero;
  logic [2:0] ALUcontrol;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic       IorD, RegDst, MemtoReg;
  logic       IRWrite, MemWrite, RegWrite, PCEn;
  logic [3:0] state;

  int n_checks = 0;
  int n_err    = 0;

  localparam int K_LW   = 0;
  localparam int K_SW   = 1;
  localparam int K_R    = 2;
  localparam int K_RBAD = 3;
  localparam int K_ADDI = 4;
  localparam int K_BEQ  = 5;
  localparam int K_J    = 6;
  localparam int K_ILL  = 7;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n),
    .opcode(opcode), .funct(funct), .zero(zero),
    .ALUcontrol(ALUcontrol), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .IorD(IorD),
    .RegDst(RegDst), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .PCEn(PCEn), .state(state)
  );

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit legal_funct(input logic [5:0] f);
    return f == 6'd32 || f == 6'd34 || f == 6'd36 ||
           f == 6'd37 || f == 6'd42;
  endfunction

  function automatic int classify(input logic [5:0] op,
                                  input logic [5:0] f);
    case (op)
      6'd0:  return legal_funct(f) ? K_R : K_RBAD;
      6'd35: return K_LW;
      6'd43: return K_SW;
      6'd4:  return K_BEQ;
      6'd8:  return K_ADDI;
      6'd2:  return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'd32: return 3'b010;
      6'd34: return 3'b110;
      6'd36: return 3'b001;
      6'd37: return 3'b000;
      default: return 3'b111;
    endcase
  endfunction

  // zf < 0 : random zero each cycle; else forced value.
  // abort_at >= 0 : pull reset during that step.
  task automatic run(input logic [5:0] op,
                     input logic [5:0] f,
                     input int zf,
                     input int abort_at);
    int k;
    int sq[$];
    int n;
    string t;
    k = classify(op, f);
    case (k)
      K_LW:   sq = '{0, 1, 2, 3, 4};
      K_SW:   sq = '{0, 1, 2, 5};
      K_R:    sq = '{0, 1, 6, 7};
      K_ADDI: sq = '{0, 1, 9, 10};
      K_BEQ:  sq = '{0, 1, 8};
      K_J:    sq = '{0, 1, 11};
      default: sq = '{0, 1};
    endcase
    n = sq.size();
    opcode = op;
    funct  = f;
    for (int s = 0; s < n; s++) begin
      logic [2:0] e_alu;
      logic [1:0] e_b, e_pcs;
      bit wb;
      zero = (zf < 0) ? 1'($urandom) : 1'(zf);
      #1;
      t = $sformatf("k%0d op%0h f%0h s%0d", k, op, f, s);
      wb = (k == K_LW || k == K_R || k == K_ADDI);
      e_alu = 3'b010;
      if (k == K_R && s == 2) e_alu = alu_of(f);
      if (k == K_BEQ && s == 2) e_alu = 3'b110;
      e_b = 2'b00;
      if (s == 0) e_b = 2'b01;
      if (s == 1) e_b = 2'b11;
      if (s == 2 && (k == K_LW || k == K_SW || k == K_ADDI))
        e_b = 2'b10;
      e_pcs = 2'b00;
      if (s == 2 && k == K_BEQ) e_pcs = 2'b01;
      if (s == 2 && k == K_J)   e_pcs = 2'b10;
      chk({t, " state"}, state, 4'(sq[s]));
      chk({t, " IRWrite"}, 4'(IRWrite), 4'(s == 0));
      chk({t, " PCEn"}, 4'(PCEn),
          4'(s == 0 || (s == 2 && k == K_J) ||
             (s == 2 && k == K_BEQ && zero)));
      chk({t, " MemWrite"}, 4'(MemWrite),
          4'(k == K_SW && s == 3));
      chk({t, " RegWrite"}, 4'(RegWrite),
          4'(wb && s == n - 1));
      chk({t, " ALUcontrol"}, 4'(ALUcontrol), 4'(e_alu));
      chk({t, " ALUSrcA"}, 4'(ALUSrcA),
          4'(s == 2 && k != K_J));
      chk({t, " ALUSrcB"}, 4'(ALUSrcB), 4'(e_b));
      chk({t, " PCSrc"}, 4'(PCSrc), 4'(e_pcs));
      chk({t, " IorD"}, 4'(IorD),
          4'(s == 3 && (k == K_LW || k == K_SW)));
      chk({t, " RegDst"}, 4'(RegDst), 4'(k == K_R && s == 3));
      chk({t, " MemtoReg"}, 4'(MemtoReg),
          4'(k == K_LW && s == 4));
      if (s == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk({t, " rst state"}, state, 4'd0);
        chk({t, " rst RegWrite"}, 4'(RegWrite), 4'd0);
        chk({t, " rst IRWrite"}, 4'(IRWrite), 4'd0);
        chk({t, " rst PCEn"}, 4'(PCEn), 4'd0);
        @(posedge clk);
        #1;
        chk({t, " rst hold"}, state, 4'd0);
        chk({t, " rst ALUSrcB"}, 4'(ALUSrcB), 4'd1);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] op, f;
    logic [5:0] ops [7];
    logic [5:0] fns [5];
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd63};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    rst_n  = 1'b0;
    opcode = 6'd0;
    funct  = 6'd0;
    zero   = 1'b1;
    #3;
    chk("reset state", state, 4'd0);
    chk("reset IRWrite", 4'(IRWrite), 4'd0);
    chk("reset PCEn", 4'(PCEn), 4'd0);
    chk("reset ALUSrcB", 4'(ALUSrcB), 4'd1);
    chk("reset ALUcontrol", 4'(ALUcontrol), 4'd2);
    @(negedge clk);
    rst_n = 1'b1;

    run(6'b100011, 6'd0, -1, -1);
    run(6'b000000, 6'b101010, -1, -1);
    run(6'b000100, 6'd0, 1, -1);
    run(6'b000100, 6'd0, 0, -1);
    run(6'b101011, 6'd0, -1, -1);
    run(6'b000010, 6'd0, -1, -1);
    run(6'b111111, 6'd0, -1, -1);
    run(6'b000000, 6'b000000, -1, -1);
    run(6'b100011, 6'd0, -1, 4);
    run(6'b001000, 6'd5, -1, -1);

    for (int i = 0; i < 200; i++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel < 7) op = ops[sel];
      else op = 6'($urandom);
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else f = fns[$urandom_range(0, 4)];
      run(op, f, -1, ($urandom_range(0, 19) == 0) ?
          int'($urandom_range(0, 2)) : -1);
    end
    #1;
    chk("final state", state, 4'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
